program_loader: RTL and testbench
=================================

# program_loader

Synthesizable program loader and run controller for the 5-stage pipeline RISC-V core. Accepts a stream of 32-bit instruction words and writes them big-endian, one byte per cycle, into the core's byte-wide instruction RAM, with a NOP forced at address 0. It then holds the core in reset for a programmable number of cycles, releases it, and counts run cycles until a cycle budget expires or the core requests halt. It sits between a host/test stream and the `Core` reset and instruction-memory write port, replacing hand-poked RAM preload.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width of instruction RAM; capacity 2^ADDR_W bytes.
- `CYC_W`, 16: width of `cycle_count`.
- `MAX_CYCLES`, 75: run-cycle budget, 1..2^CYC_W-1.
- `RESET_HOLD`, 3: cycles `core_reset` stays high after load, >=1.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high; fixed polarity and synchronicity.
- `start`  in  1  begin load sequence; sampled in IDLE or DONE only.
- `load_valid`  in  1  `load_word` valid.
- `load_word`  in  32  instruction word.
- `load_last`  in  1  qualifies final word of the program.
- `load_ready`  out  1  loader accepts word this cycle.
- `halt_req`  in  1  core requests stop; sampled in RUN.
- `ram_we`  out  1  byte write strobe to instruction RAM.
- `ram_addr`  out  ADDR_W  byte address.
- `ram_wdata`  out  8  byte data.
- `core_reset`  out  1  reset to `Core`.
- `core_mem_en`  out  1  `mem_en` to `Core`.
- `cycle_count`  out  CYC_W  run cycles elapsed.
- `done`  out  1  run finished.
- `overflow`  out  1  sticky; program exceeded RAM.

## Operation
- States: IDLE, NOPW, LOAD, WRITE, HOLD, RUN, DONE.
- IDLE: `start` -> NOPW. Write pointer `wptr` cleared to 0.
- NOPW: 4 cycles writing 0x00 to addresses 0..3. Then LOAD with `wptr`=4.
- LOAD: `load_ready`=1. A handshake (`load_valid & load_ready`) captures the word and `load_last`, then -> WRITE.
- WRITE: 4 cycles writing bytes [31:24], [23:16], [15:8], [7:0] at `wptr`, `wptr`+1, `wptr`+2, `wptr`+3, then `wptr`+=4.
  - Captured `load_last`=1 -> HOLD.
  - Otherwise -> LOAD.
- Overflow: if `wptr`+3 > 2^ADDR_W-1 on handshake, the word is dropped (no writes), `overflow` is set, and the state goes to HOLD regardless of `load_last`. No address wrap ever occurs.
- HOLD: `core_reset`=1 for RESET_HOLD cycles, then -> RUN.
- RUN: `core_reset`=0. `cycle_count` increments each cycle.
  - Leaves when the increment reaches MAX_CYCLES, or when `halt_req`=1; either -> DONE.
  - `halt_req` and the budget in the same cycle -> DONE, with the count incremented.
- DONE: `core_reset`=1, `done`=1, `cycle_count` frozen.
  - `start` -> NOPW; clears `cycle_count`, `done` and `overflow`.
- `core_mem_en`=1 in HOLD, RUN and DONE; 0 otherwise.
- `start` in any state other than IDLE or DONE is ignored. `load_valid` outside LOAD is ignored.
- Reset mid-operation (any state): immediately returns to IDLE. RAM contents are left untouched.

## Timing
- Reset values: `load_ready` 0, `ram_we` 0, `ram_addr` 0, `ram_wdata` 0, `core_reset` 1, `core_mem_en` 0, `cycle_count` 0, `done` 0, `overflow` 0.
- All outputs are registered; `load_ready` is decoded from registered state.
- Start to first RAM write: `start` sampled at edge E; `ram_we` high in cycle E+1.
- Handshake to writes: handshake at edge T; byte writes in cycles T+1..T+4; `load_ready` high again in cycle T+5.
- Throughput: 1 word per 5 cycles at best.
- HOLD to RUN: last write cycle W; `core_reset` high in cycles W+1..W+RESET_HOLD; low from W+RESET_HOLD+1.
- Run termination: `cycle_count`=MAX_CYCLES and `done`=1 on the same edge; `core_reset` rises with them.

## Structure
- Shared package `loader_pkg` holds:
  - state enum `loader_state_t`
  - `NOP_WORD` = 32'h0000_0000
  - byte-lane constant `BYTES_PER_WORD` = 4
- One sub-module, `be_byte_serializer`: takes a 32-bit word and a base address and emits 4 big-endian byte writes on consecutive cycles with a `busy` flag. It is shared by NOPW and WRITE.
- Top FSM, hold counter and run counter live in `program_loader`.

## Test plan
- Reset, then `start`, then words 0x00210133 (`load_last`=0) and 0x01080833 (`load_last`=1) -> RAM bytes 0..11 = 00 00 00 00 00 21 01 33 01 08 08 33; `core_reset` falls 3 cycles after the last write.
- `MAX_CYCLES`=75, no halt -> `done` rises with `cycle_count`=75; `core_reset` re-asserted; count frozen for 10 further cycles.
- `halt_req` pulsed in 20th RUN cycle -> `done`=1 and `cycle_count`=20 the next cycle.
- `ADDR_W`=4, 4 words streamed -> words 1..3 land at 4..15; word 4 dropped, `overflow`=1, HOLD entered, no write to address 0.
- `load_valid` held high continuously -> exactly one handshake per 5 cycles; `start` during WRITE ignored.
- `reset` asserted mid-WRITE (after 2 bytes) -> outputs take reset values asynchronously; a new `start` reloads from address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// the word forced at address 0, and the byte-lane count of an instruction word.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NOPW  = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } loader_state_t;

  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Instruction-word stream from the host into the program loader.
interface program_loader_if;

  // A word transfers on a clock edge where load_valid and load_ready are both
  // high; load_word/load_last must be stable while load_valid is high, and the
  // loader never makes load_ready depend on load_valid.
  logic        load_valid;
  logic [31:0] load_word;
  logic        load_last;
  logic        load_ready;

  modport master (output load_valid, load_word, load_last, input load_ready);
  modport slave  (input load_valid, load_word, load_last, output load_ready);

endinterface

// File: rtl/be_byte_serializer.sv
// Emits one 32-bit word as four big-endian byte writes on consecutive cycles,
// starting at a base address; all outputs are registered.
module be_byte_serializer
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [31:0]       word,
  input  logic [ADDR_W-1:0] base,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              busy,
  output logic              last_lane
);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [23:0]       rest_q, rest_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rest_d  = rest_q;
    idx_d   = idx_q;
    if (go) begin
      we_d    = 1'b1;
      addr_d  = base;
      wdata_d = word[31:24];
      rest_d  = word[23:0];
      idx_d   = 2'd0;
    end else if (we_q) begin
      if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
        we_d = 1'b0;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        wdata_d = rest_q[23:16];
        rest_d  = {rest_q[15:0], 8'h00};
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rest_q  <= '0;
      idx_q   <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rest_q  <= rest_d;
      idx_q   <= idx_d;
    end
  end

  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign busy      = we_q;
  assign last_lane = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a program into the core's byte-wide instruction RAM (NOP at address 0),
// then sequences core reset release and a bounded run with halt support.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 75,
  parameter int RESET_HOLD = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  program_loader_if.slave      ld,
  input  logic                 halt_req,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 core_reset,
  output logic                 core_mem_en,
  output logic [CYC_W-1:0]     cycle_count,
  output logic                 done,
  output logic                 overflow,
  output loader_state_t        dbg_state
);

  localparam int              PW       = ADDR_W + 2;
  localparam logic [PW-1:0]   RAM_LAST = PW'((1 << ADDR_W) - 1);
  localparam int              HW       = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic              last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CYC_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              core_reset_q, core_reset_d;
  logic              mem_en_q, mem_en_d;
  logic              done_q, done_d;

  logic              ser_go, ser_busy, ser_last_lane;
  logic [31:0]       ser_word;
  logic [ADDR_W-1:0] ser_base;
  logic [PW-1:0]     end_addr;
  logic              word_fits;

  // wptr is one bit wider than the RAM address so a completely full RAM is
  // representable; a word is accepted only if all four bytes fit below the top.
  assign end_addr  = PW'(wptr_q) + PW'(BYTES_PER_WORD - 1);
  assign word_fits = (end_addr <= RAM_LAST);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    last_d   = last_q;
    hold_d   = hold_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ser_go   = 1'b0;
    ser_word = NOP_WORD;
    ser_base = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_NOPW;
          wptr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          ser_go  = 1'b1;
        end
      end
      S_NOPW, S_WRITE: begin
        if (ser_busy && ser_last_lane) begin
          wptr_d = wptr_q + (ADDR_W + 1)'(BYTES_PER_WORD);
          if (state_q == S_WRITE && last_q) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (ld.load_valid) begin
          if (word_fits) begin
            ser_go   = 1'b1;
            ser_word = ld.load_word;
            ser_base = wptr_q[ADDR_W-1:0];
            last_d   = ld.load_last;
            state_d  = S_WRITE;
          end else begin
            ovf_d   = 1'b1;
            state_d = S_HOLD;
            hold_d  = '0;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HW'(RESET_HOLD - 1)) state_d = S_RUN;
        else                               hold_d  = hold_q + HW'(1);
      end
      S_RUN: begin
        count_d = count_q + CYC_W'(1);
        if (count_d == CYC_W'(MAX_CYCLES) || halt_req) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered outputs follow the state being entered, so they change on the
    // same edge as the transition.
    core_reset_d = (state_d != S_RUN);
    mem_en_d     = (state_d == S_HOLD) || (state_d == S_RUN) || (state_d == S_DONE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      last_q       <= 1'b0;
      hold_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      core_reset_q <= 1'b1;
      mem_en_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      core_reset_q <= core_reset_d;
      mem_en_q     <= mem_en_d;
      done_q       <= done_d;
    end
  end

  be_byte_serializer #(.ADDR_W(ADDR_W)) u_ser (
    .clock     (clock),
    .reset     (reset),
    .go        (ser_go),
    .word      (ser_word),
    .base      (ser_base),
    .we        (ram_we),
    .addr      (ram_addr),
    .wdata     (ram_wdata),
    .busy      (ser_busy),
    .last_lane (ser_last_lane)
  );

  assign ld.load_ready = (state_q == S_LOAD);
  assign core_reset    = core_reset_q;
  assign core_mem_en   = mem_en_q;
  assign cycle_count   = count_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected RAM writes are queued
// from a word-level model of the load rules; a monitor pops them on every write.
module tb_program_loader;
  import loader_pkg::*;

  localparam int CLK_P     = 10;
  localparam int MAXC      = 75;
  localparam int RH        = 3;
  localparam int RAM_BYTES = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          ram_we;
  logic [7:0]    ram_addr, ram_wdata;
  logic          core_reset, core_mem_en, done, overflow;
  logic [15:0]   cycle_count;
  loader_state_t dbg_state;

  program_loader_if lif();

  program_loader dut (
    .clock       (clk),
    .reset       (rst),
    .start       (start),
    .ld          (lif),
    .halt_req    (halt_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .core_reset  (core_reset),
    .core_mem_en (core_mem_en),
    .cycle_count (cycle_count),
    .done        (done),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  int          tests_run = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mem [RAM_BYTES];
  logic [31:0] prog_w[$];
  logic        prog_l[$];
  int          mwptr = 0;
  bit          model_ovf = 1'b0;
  logic [7:0]  tp [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h21,
                           8'h01, 8'h33, 8'h01, 8'h08, 8'h08, 8'h33};

  // ---------------- clock ----------------
  initial forever #(CLK_P / 2) clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [15:0] mon_e;
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== mon_e) begin
          fails++;
          $display("FAIL ram_write: got addr %0h data %0h expected addr %0h data %0h",
                   ram_addr, ram_wdata, mon_e[15:8], mon_e[7:0]);
        end
      end
      mem[ram_addr] = ram_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({8'(k), 8'h00});
    mwptr     = 4;
    model_ovf = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_to_write", ram_we, 1);
    check("start_clears_done", done, 0);
    check("start_clears_count", cycle_count, 0);
    check("start_clears_overflow", overflow, 0);
  endtask

  task automatic build_prog(input int n);
    prog_w.delete();
    prog_l.delete();
    for (int i = 0; i < n; i++) begin
      prog_w.push_back($urandom);
      prog_l.push_back(i == n - 1);
    end
  endtask

  task automatic send_words(input bit cont, input bit poke);
    time         prev_t, hs_t;
    bit          have_prev;
    int          g, b, exp_gap;
    logic [31:0] w;
    have_prev = 1'b0;
    prev_t    = 0;
    for (int i = 0; i < prog_w.size(); i++) begin
      g = cont ? 0 : $urandom_range(0, 6);
      if (g > 0) begin
        lif.load_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      lif.load_valid = 1'b1;
      lif.load_word  = prog_w[i];
      lif.load_last  = prog_l[i];
      if (poke && i == 1) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      for (b = 0; b < 40; b++) begin
        @(negedge clk);
        if (lif.load_ready) break;
      end
      check("load_ready_wait", lif.load_ready, 1);
      if (!lif.load_ready) begin
        lif.load_valid = 1'b0;
        return;
      end
      @(posedge clk);
      hs_t = $time;
      #1;
      exp_gap = (g + 1 > 5) ? g + 1 : 5;
      if (have_prev) check("handshake_spacing", (hs_t - prev_t) / CLK_P, exp_gap);
      prev_t    = hs_t;
      have_prev = 1'b1;
      if (mwptr + 3 > RAM_BYTES - 1) begin
        model_ovf = 1'b1;
        break;
      end
      w = prog_w[i];
      for (int k = 0; k < 4; k++)
        exp_q.push_back({8'(mwptr + k), 8'((w >> (24 - 8 * k)) & 32'hFF)});
      mwptr += 4;
    end
    lif.load_valid = 1'b0;
  endtask

  // Called right after the final handshake edge.
  task automatic check_hold();
    int wlen;
    wlen = model_ovf ? 0 : 4;
    for (int n = 1; n <= wlen + RH + 1; n++) begin
      @(negedge clk);
      if (wlen > 0 && n == wlen) check("mem_en_during_write", core_mem_en, 0);
      if (n == wlen + 1)         check("hold_mem_en", core_mem_en, 1);
      if (n == wlen + RH)        check("hold_core_reset", core_reset, 1);
      if (n == wlen + RH + 1)    check("run_core_reset", core_reset, 0);
    end
  endtask

  // Called at the negedge of the first RUN cycle.
  task automatic run_phase(input int halt_at);
    int exp_cnt, bad, k;
    exp_cnt = (halt_at >= 1 && halt_at < MAXC) ? halt_at : MAXC;
    bad = 0;
    for (k = 1; k <= MAXC + 20; k++) begin
      if (cycle_count != 16'(k - 1) || done) bad++;
      if (k == halt_at) halt_req = 1'b1;
      @(posedge clk); #1 halt_req = 1'b0;
      @(negedge clk);
      if (done) break;
    end
    check("run_track", bad, 0);
    check("run_done", done, 1);
    check("run_count", cycle_count, exp_cnt);
    check("done_core_reset", core_reset, 1);
    check("done_mem_en", core_mem_en, 1);
    bad = 0;
    for (int f = 0; f < 10; f++) begin
      halt_req       = 1'($urandom_range(0, 1));
      lif.load_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cycle_count != 16'(exp_cnt) || !done || lif.load_ready) bad++;
    end
    halt_req       = 1'b0;
    lif.load_valid = 1'b0;
    check("done_frozen", bad, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, bad;
    bit c;
    lif.load_valid = 1'b0;
    lif.load_word  = '0;
    lif.load_last  = 1'b0;

    @(negedge clk);
    check("rst_load_ready", lif.load_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_mem_en", core_mem_en, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Reference program, run to the cycle budget.
    do_start();
    prog_w = '{32'h0021_0133, 32'h0108_0833};
    prog_l = '{1'b0, 1'b1};
    send_words(1'b0, 1'b0);
    check_hold();
    for (int i = 0; i < 12; i++) check("tp_ram_byte", mem[i], tp[i]);
    run_phase(0);

    // Continuous valid, start poked during WRITE, halt in 20th RUN cycle.
    do_start();
    build_prog(4);
    send_words(1'b1, 1'b1);
    check_hold();
    run_phase(20);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      c = 1'($urandom_range(0, 1));
      do_start();
      build_prog(n);
      send_words(c, c && n >= 2);
      check_hold();
      run_phase($urandom_range(1, 90));
    end

    // Overflow: 63 words fill addresses 4..255, the 64th is dropped.
    do_start();
    build_prog(64);
    for (int i = 0; i < 64; i++) prog_l[i] = 1'b0;
    send_words(1'b1, 1'b0);
    check("model_overflow_reached", model_ovf, 1);
    check_hold();
    check("overflow_flag", overflow, 1);
    check("ram_addr0_kept", mem[0], 8'h00);
    run_phase($urandom_range(1, 90));

    // Asynchronous reset in the middle of a word write.
    do_start();
    build_prog(1);
    send_words(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    bad = 0;
    if (lif.load_ready !== 1'b0) bad++;
    if (ram_addr !== 8'h00)      bad++;
    if (ram_wdata !== 8'h00)     bad++;
    if (core_reset !== 1'b1)     bad++;
    if (core_mem_en !== 1'b0)    bad++;
    if (cycle_count !== 16'h0)   bad++;
    if (done !== 1'b0)           bad++;
    if (overflow !== 1'b0)       bad++;
    check("async_reset_we", ram_we, 0);
    check("async_reset_outputs", bad, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_start();
    build_prog(1);
    send_words(1'b0, 1'b0);
    check_hold();
    run_phase(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
